// File: rtl/cyphertext_reader_pkg.sv
// Shared widths and FSM state encoding for the cyphertext readout path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cyphertext_reader_pkg;

   localparam int CT_TEXT_WIDTH = 128;
   localparam int CT_ADDR_WIDTH = 8;
   localparam int CT_BYTE_W     = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
   } ct_state_t;

   // Number of stream bytes carried by one cyphertext block (checksum excluded).
   function automatic int bytes_per_block(input int text_width);
      return text_width / CT_BYTE_W;
   endfunction

endpackage

// File: rtl/cyphertext_reader_byte_serializer.sv
// ct_byte_serializer: turns one loaded block into a MSB-first byte stream (+ XOR checksum byte if CT_READ_CHECKSUM_EN).
// Latency: first byte valid the cycle after load_i; one byte per cycle while byte_ready_i is high.
// Backpressure: byte_ready_i low holds byte_o and all state; block_done_o pulses on the last accepted byte.
module ct_byte_serializer
   import cyphertext_reader_pkg::*;
#(
   parameter int TEXT_WIDTH = CT_TEXT_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  load_i,
   input  logic [TEXT_WIDTH-1:0] load_dat_i,
   output logic [CT_BYTE_W-1:0]  byte_o,
   output logic                  byte_valid_o,
   input  logic                  byte_ready_i,
   output logic                  block_done_o
);

   localparam int BYTES_PER_BLOCK = bytes_per_block(TEXT_WIDTH);
`ifdef CT_READ_CHECKSUM_EN
   localparam int LAST_IDX = BYTES_PER_BLOCK;
`else
   localparam int LAST_IDX = BYTES_PER_BLOCK - 1;
`endif
   localparam int CNT_W = $clog2(BYTES_PER_BLOCK + 1);

   logic [TEXT_WIDTH-1:0] shift_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  vld_q;
   logic                  xfer;
   logic                  last_byte;
   logic [CT_BYTE_W-1:0]  cur_byte;
`ifdef CT_READ_CHECKSUM_EN
   logic [CT_BYTE_W-1:0]  csum_q;
`endif

   assign xfer         = vld_q & byte_ready_i;
   assign last_byte    = (cnt_q == CNT_W'(LAST_IDX));
   assign block_done_o = xfer & last_byte;
   assign byte_valid_o = vld_q;

`ifdef CT_READ_CHECKSUM_EN
   assign cur_byte = (cnt_q == CNT_W'(BYTES_PER_BLOCK)) ? csum_q
                                                        : shift_q[TEXT_WIDTH-1 -: CT_BYTE_W];
`else
   assign cur_byte = shift_q[TEXT_WIDTH-1 -: CT_BYTE_W];
`endif

   // Stream data is forced to zero whenever nothing is being offered.
   assign byte_o = vld_q ? cur_byte : '0;

   // Load a fresh block, then shift one byte out per accepted transfer.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
`ifdef CT_READ_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else if (load_i) begin
         shift_q <= load_dat_i;
         cnt_q   <= '0;
         vld_q   <= 1'b1;
`ifdef CT_READ_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else if (xfer) begin
         shift_q <= {shift_q[TEXT_WIDTH-CT_BYTE_W-1:0], {CT_BYTE_W{1'b0}}};
         cnt_q   <= cnt_q + CNT_W'(1);
`ifdef CT_READ_CHECKSUM_EN
         // The shift register is empty while the checksum byte is sent, so this folds in zero there.
         csum_q  <= csum_q ^ shift_q[TEXT_WIDTH-1 -: CT_BYTE_W];
`endif
         if (last_byte) begin
            vld_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cyphertext_reader.sv
// cyphertext_reader: reads count_i blocks from base_addr_i (wrapping) out of the cyphertext RAM and streams them as bytes.
// Latency: start -> rd_en 1 cycle, rd_en -> first byte_valid 2 cycles, 2 idle cycles between blocks.
// Backpressure: byte_ready_i low stalls the stream; the next RAM read waits for the current block to drain. Option: CT_READ_CHECKSUM_EN.
module cyphertext_reader
   import cyphertext_reader_pkg::*;
#(
   parameter int TEXT_WIDTH = CT_TEXT_WIDTH,
   parameter int ADDR_WIDTH = CT_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   count_i,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [TEXT_WIDTH-1:0] rd_data_i,
   output logic [CT_BYTE_W-1:0]  byte_o,
   output logic                  byte_valid_o,
   input  logic                  byte_ready_i,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam logic [ADDR_WIDTH:0]   ONE_BLOCK = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = 1;

   ct_state_t             state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH:0]   blocks_q;
   logic                  ser_load;
   logic                  ser_block_done;

   // RAM data is valid in CAPTURE, one cycle after the FETCH strobe.
   assign ser_load = (state_q == CAPTURE);

   ct_byte_serializer #(
      .TEXT_WIDTH (TEXT_WIDTH)
   ) u_ser (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .load_i       (ser_load),
      .load_dat_i   (rd_data_i),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .byte_ready_i (byte_ready_i),
      .block_done_o (ser_block_done)
   );

   // Readout sequencer: addressing, block counting and registered strobes.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         blocks_q  <= '0;
         rd_en_o   <= 1'b0;
         rd_addr_o <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         rd_en_o   <= 1'b0;
         rd_addr_o <= '0;
         done_o    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (count_i != '0) begin
                     addr_q    <= base_addr_i;
                     blocks_q  <= count_i;
                     rd_en_o   <= 1'b1;
                     rd_addr_o <= base_addr_i;
                     busy_o    <= 1'b1;
                     state_q   <= FETCH;
                  end else begin
                     done_o  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            FETCH: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               state_q <= SEND;
            end
            SEND: begin
               if (ser_block_done) begin
                  if (blocks_q == ONE_BLOCK) begin
                     blocks_q <= '0;
                     busy_o   <= 1'b0;
                     done_o   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     blocks_q  <= blocks_q - ONE_BLOCK;
                     addr_q    <= addr_q + ADDR_INC;
                     rd_en_o   <= 1'b1;
                     rd_addr_o <= addr_q + ADDR_INC;
                     state_q   <= FETCH;
                  end
               end
            end
            DONE: begin
               // A start arriving together with done_o is dropped here.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cyphertext_reader.sv
// Bench for cyphertext_reader: RAM model, randomized backpressure, queue-based reference of the expected stream.
module tb_cyphertext_reader;

   localparam int TW  = 128;
   localparam int AW  = 8;
   localparam int BPB = TW / 8;
`ifdef CT_READ_CHECKSUM_EN
   localparam int BPS = BPB + 1;
`else
   localparam int BPS = BPB;
`endif

   logic          clk_i   = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          start_i = 1'b0;
   logic [AW-1:0] base_addr_i = '0;
   logic [AW:0]   count_i = '0;
   logic          rd_en_o;
   logic [AW-1:0] rd_addr_o;
   logic [TW-1:0] rd_data_i;
   logic [7:0]    byte_o;
   logic          byte_valid_o;
   logic          byte_ready_i = 1'b0;
   logic          busy_o;
   logic          done_o;

   cyphertext_reader #(.TEXT_WIDTH(TW), .ADDR_WIDTH(AW)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .count_i      (count_i),
      .rd_en_o      (rd_en_o),
      .rd_addr_o    (rd_addr_o),
      .rd_data_i    (rd_data_i),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .byte_ready_i (byte_ready_i),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rmode = 0;

   logic [TW-1:0] mem [256];

   // Synchronous RAM with one cycle of read latency.
   always @(posedge clk_i) begin
      if (rd_en_o) rd_data_i <= mem[rd_addr_o];
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
      end
   endtask

   // Observed activity, logged mid-cycle.
   int         q_rd_addr[$];
   int         q_rd_cyc[$];
   int         q_vrise[$];
   logic [7:0] q_byte[$];
   int         q_byte_cyc[$];
   int         q_done[$];
   logic       done_busy;
   logic       prev_v = 1'b0, prev_r = 1'b0;
   logic [7:0] prev_b = '0;

   always @(negedge clk_i) begin
      if (rst_n_i) begin
         if (rd_en_o) begin
            q_rd_addr.push_back(int'(rd_addr_o));
            q_rd_cyc.push_back(cyc);
         end
         if (byte_valid_o && !prev_v) q_vrise.push_back(cyc);
         if (!byte_valid_o) check("idle_byte_zero", 32'(byte_o), 32'h0);
         else if (prev_v && !prev_r) check("stall_hold", 32'(byte_o), 32'(prev_b));
         if (byte_valid_o && byte_ready_i) begin
            q_byte.push_back(byte_o);
            q_byte_cyc.push_back(cyc);
         end
         if (done_o) begin
            q_done.push_back(cyc);
            done_busy = busy_o;
         end
      end
      prev_v = byte_valid_o;
      prev_r = byte_ready_i;
      prev_b = byte_o;
   end

   // Ready patterns: 0 = always, 1 = 1,0,0 repeating, 2 = random.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         case (rmode)
            0:       byte_ready_i = 1'b1;
            1:       byte_ready_i = (cyc % 3 == 0);
            default: byte_ready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Reference: the stream is every block of the range, MSB byte first, optionally followed by its XOR.
   int         exp_addr[$];
   logic [7:0] exp_byte[$];

   function automatic void build_exp(input logic [7:0] base, input int cnt);
      logic [7:0]    a;
      logic [TW-1:0] blk;
      logic [7:0]    x;
      logic [7:0]    v;
      exp_addr.delete();
      exp_byte.delete();
      for (int b = 0; b < cnt; b++) begin
         a   = base + 8'(b);
         blk = mem[a];
         x   = 8'h00;
         exp_addr.push_back(int'(a));
         for (int i = 0; i < BPB; i++) begin
            v = blk[TW-1-8*i -: 8];
            x = x ^ v;
            exp_byte.push_back(v);
         end
`ifdef CT_READ_CHECKSUM_EN
         exp_byte.push_back(x);
`endif
      end
   endfunction

   function automatic void clear_logs();
      q_rd_addr.delete(); q_rd_cyc.delete(); q_vrise.delete();
      q_byte.delete(); q_byte_cyc.delete(); q_done.delete();
   endfunction

   task automatic run_txn(input string tag, input logic [7:0] base, input logic [8:0] cnt,
                          input int mode, input int spur_off);
      int start_cyc;
      int budget;
      int done_seen_at;
      int last;
      build_exp(base, int'(cnt));
      clear_logs();
      rmode = mode;
      @(posedge clk_i); #1;
      start_i = 1'b1; base_addr_i = base; count_i = cnt; start_cyc = cyc;
      @(posedge clk_i); #1;
      start_i = 1'b0; base_addr_i = 8'($urandom); count_i = 9'($urandom);
      check({tag, "_busy_after_start"}, 32'(busy_o), (cnt != 0) ? 32'h1 : 32'h0);
      budget = 0;
      done_seen_at = -1;
      while (budget < 3000) begin
         if (q_done.size() > 0 && done_seen_at < 0) done_seen_at = cyc;
         if (done_seen_at >= 0 && cyc - done_seen_at >= 6) break;
         @(posedge clk_i); #1;
         start_i = (spur_off > 0 && cyc - start_cyc == spur_off);
         if (start_i) begin
            base_addr_i = 8'h77;
            count_i     = 9'd1;
         end
         budget++;
      end
      start_i = 1'b0;
      check({tag, "_done_seen"}, 32'(q_done.size() > 0), 32'h1);
      check({tag, "_done_count"}, 32'(q_done.size()), 32'h1);
      check({tag, "_n_reads"}, 32'(q_rd_addr.size()), 32'(exp_addr.size()));
      check({tag, "_n_bytes"}, 32'(q_byte.size()), 32'(exp_byte.size()));
      for (int k = 0; k < exp_addr.size() && k < q_rd_addr.size(); k++) begin
         check({tag, "_rd_addr"}, 32'(q_rd_addr[k]), 32'(exp_addr[k]));
         if (k == 0) check({tag, "_start_to_rd"}, 32'(q_rd_cyc[k]), 32'(start_cyc + 1));
         else if (q_byte_cyc.size() >= k * BPS)
            check({tag, "_block_gap"}, 32'(q_rd_cyc[k]), 32'(q_byte_cyc[k*BPS-1] + 1));
         if (k < q_vrise.size()) check({tag, "_rd_to_valid"}, 32'(q_vrise[k]), 32'(q_rd_cyc[k] + 2));
         if (mode == 0) begin
            for (int i = 0; i < BPS; i++) begin
               if (k*BPS + i < q_byte_cyc.size())
                  check({tag, "_byte_timing"}, 32'(q_byte_cyc[k*BPS+i]), 32'(q_rd_cyc[k] + 2 + i));
            end
         end
      end
      for (int i = 0; i < exp_byte.size() && i < q_byte.size(); i++)
         check({tag, "_byte"}, 32'(q_byte[i]), 32'(exp_byte[i]));
      if (q_done.size() > 0) begin
         check({tag, "_busy_at_done"}, 32'(done_busy), 32'h0);
         if (cnt == 0) begin
            check({tag, "_done_cycle"}, 32'(q_done[0]), 32'(start_cyc + 1));
         end else if (q_byte_cyc.size() > 0) begin
            last = q_byte_cyc.size() - 1;
            check({tag, "_done_cycle"}, 32'(q_done[0]), 32'(q_byte_cyc[last] + 1));
         end
      end
   endtask

   task automatic reset_mid_send();
      int budget;
      int nb;
      int nr;
      build_exp(8'h10, 2);
      clear_logs();
      rmode = 0;
      @(posedge clk_i); #1;
      start_i = 1'b1; base_addr_i = 8'h10; count_i = 9'd2;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      budget = 0;
      while (q_byte.size() < 7 && budget < 200) begin
         @(posedge clk_i); #1;
         budget++;
      end
      check("rst_reached_byte7", 32'(q_byte.size()), 32'd7);
      #2 rst_n_i = 1'b0;
      #1;
      check("rst_rd_en", 32'(rd_en_o), 32'h0);
      check("rst_rd_addr", 32'(rd_addr_o), 32'h0);
      check("rst_byte", 32'(byte_o), 32'h0);
      check("rst_valid", 32'(byte_valid_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      check("rst_done", 32'(done_o), 32'h0);
      for (int i = 0; i < 7 && i < q_byte.size(); i++)
         check("rst_partial_byte", 32'(q_byte[i]), 32'(exp_byte[i]));
      nb = q_byte.size();
      nr = q_rd_addr.size();
      repeat (3) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
      check("rst_no_more_bytes", 32'(q_byte.size()), 32'(nb));
      check("rst_no_more_reads", 32'(q_rd_addr.size()), 32'(nr));
      check("rst_no_done", 32'(q_done.size()), 32'h0);
      run_txn("post_reset", 8'h40, 9'd1, 0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      mem[8'h05] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      mem[8'h20] = {16{8'h01}};
      mem[8'h21] = {120'h0, 8'hA5};

      rst_n_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_rd_en", 32'(rd_en_o), 32'h0);
      check("reset_byte_valid", 32'(byte_valid_o), 32'h0);
      check("reset_byte", 32'(byte_o), 32'h0);
      check("reset_busy", 32'(busy_o), 32'h0);
      check("reset_done", 32'(done_o), 32'h0);
      rst_n_i = 1'b1;

      run_txn("single", 8'h05, 9'd1, 0, 0);
      run_txn("backpressure", 8'h05, 9'd1, 1, 0);
      run_txn("wrap", 8'hFE, 9'd3, 0, 0);
      run_txn("zero_count", 8'h33, 9'd0, 0, 0);
      run_txn("start_while_busy", 8'h05, 9'd2, 2, 8);
      run_txn("start_at_done", 8'h05, 9'd1, 0, 3 + BPS);
      run_txn("csum_ones", 8'h20, 9'd1, 1, 0);
      run_txn("csum_a5", 8'h21, 9'd1, 0, 0);
      reset_mid_send();
      for (int t = 0; t < 8; t++)
         run_txn("random", 8'($urandom), 9'($urandom_range(1, 4)), int'($urandom_range(0, 2)), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
